// File: rtl/riscv_mul_result_stage_pkg.sv
// Shared opcodes and FSM encodings for the multiply result stage.
package riscv_mul_result_stage_pkg;

  localparam logic [3:0] ALU_MULL = 4'b1010;
  localparam logic [3:0] ALU_MULH = 4'b1011;

  typedef enum logic [1:0] {
    MRS_IDLE  = 2'd0,
    MRS_WAIT  = 2'd1,
    MRS_DRAIN = 2'd2,
    MRS_HOLD  = 2'd3
  } mrs_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALU_MULL) || (op == ALU_MULH);
  endfunction

endpackage

// File: rtl/riscv_mul_result_stage.sv
// EX-stage multiply result tracker: waits out the sequential multiplier, slices the product,
// and hands it to writeback. Optional stall counter under MUL_STALL_CNT_EN.
module riscv_mul_result_stage
  import riscv_mul_result_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_r,
  input  logic [3:0]        id_alu_op_r,
  input  logic [RF_AW-1:0]  id_rd_idx_r,
  input  logic [2*XLEN-1:0] mul_res_r,
  input  logic              ex_stall_mul_w,
  input  logic              ex_flush_i,
  input  logic              wb_stall_i,
  output logic              ex_mul_valid_r,
  output logic [XLEN-1:0]   ex_mul_wdata_r,
  output logic [RF_AW-1:0]  ex_mul_rd_r,
  output logic              ex_stall_o
`ifdef MUL_STALL_CNT_EN
  ,
  output logic [31:0]       mul_stall_cnt_o
`endif
);

  mrs_state_e       state, state_nxt;
  logic             hi_sel;
  logic [RF_AW-1:0] rd_lat;
  logic             wait_seen;
  logic             accept, complete, release_hold;

  assign accept       = id_valid_r && is_mul_op(id_alu_op_r) && !ex_flush_i;
  // The multiplier raises its stall a cycle after issue, so the first WAIT cycle never completes.
  assign complete     = !ex_flush_i && !ex_stall_mul_w && wait_seen;
  assign release_hold = ex_flush_i || !wb_stall_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= MRS_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MRS_IDLE:  if (accept) state_nxt = MRS_WAIT;
      MRS_WAIT:  if (ex_flush_i) state_nxt = MRS_DRAIN;
                 else if (complete) state_nxt = MRS_HOLD;
      MRS_DRAIN: if (!ex_stall_mul_w) state_nxt = MRS_IDLE;
      MRS_HOLD:  if (release_hold) state_nxt = MRS_IDLE;
      default:   state_nxt = MRS_IDLE;
    endcase
  end

  always_comb begin
    ex_stall_o = 1'b0;
    if (!rst_i) begin
      case (state)
        MRS_WAIT, MRS_DRAIN: ex_stall_o = 1'b1;
        MRS_HOLD:            ex_stall_o = wb_stall_i;
        default:             ex_stall_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_sel         <= 1'b0;
      rd_lat         <= '0;
      wait_seen      <= 1'b0;
      ex_mul_valid_r <= 1'b0;
      ex_mul_wdata_r <= '0;
      ex_mul_rd_r    <= '0;
    end else begin
      wait_seen <= (state == MRS_WAIT);
      if (state == MRS_IDLE && accept) begin
        hi_sel <= (id_alu_op_r == ALU_MULH);
        rd_lat <= id_rd_idx_r;
      end
      if (state == MRS_WAIT && complete) begin
        ex_mul_wdata_r <= hi_sel ? mul_res_r[2*XLEN-1:XLEN] : mul_res_r[XLEN-1:0];
        ex_mul_rd_r    <= rd_lat;
        ex_mul_valid_r <= 1'b1;
      end
      if (state == MRS_HOLD && release_hold) ex_mul_valid_r <= 1'b0;
    end
  end

`ifdef MUL_STALL_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           mul_stall_cnt_o <= '0;
    else if (ex_stall_o) mul_stall_cnt_o <= mul_stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_riscv_mul_result_stage.sv
// Scoreboard bench: the driver plays the sequential multiplier and pushes expected results;
// a negedge monitor compares every presented result.
module tb_riscv_mul_result_stage;
  import riscv_mul_result_stage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_r;
  logic [3:0]  id_alu_op_r;
  logic [4:0]  id_rd_idx_r;
  logic [63:0] mul_res_r;
  logic        ex_stall_mul_w;
  logic        ex_flush_i;
  logic        wb_stall_i;
  logic        ex_mul_valid_r;
  logic [31:0] ex_mul_wdata_r;
  logic [4:0]  ex_mul_rd_r;
  logic        ex_stall_o;
`ifdef MUL_STALL_CNT_EN
  logic [31:0] mul_stall_cnt_o;
`endif

  riscv_mul_result_stage #(.XLEN(32), .RF_AW(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_r(id_valid_r), .id_alu_op_r(id_alu_op_r),
    .id_rd_idx_r(id_rd_idx_r), .mul_res_r(mul_res_r), .ex_stall_mul_w(ex_stall_mul_w),
    .ex_flush_i(ex_flush_i), .wb_stall_i(wb_stall_i), .ex_mul_valid_r(ex_mul_valid_r),
    .ex_mul_wdata_r(ex_mul_wdata_r), .ex_mul_rd_r(ex_mul_rd_r), .ex_stall_o(ex_stall_o)
`ifdef MUL_STALL_CNT_EN
    , .mul_stall_cnt_o(mul_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: stalled cycles check stability against the head entry, the handshake cycle pops it.
  always @(negedge clk_i) begin
    if (!rst_i && ex_mul_valid_r) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got valid with data 0x%08h, expected no result", ex_mul_wdata_r);
      end else begin
        check("wdata", ex_mul_wdata_r, sb_q[0].data);
        check("rd", {27'd0, ex_mul_rd_r}, {27'd0, sb_q[0].rd});
        if (!wb_stall_i) void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one multiply and play the multiplier: stall rises one cycle after issue, stays n cycles.
  task automatic do_mul(input logic [63:0] prod, input logic hi, input logic [4:0] rd,
                        input int n, input int k, input logic [31:0] exp_data);
    exp_t e;
    tick();
    id_valid_r  = 1'b1;
    id_alu_op_r = hi ? ALU_MULH : ALU_MULL;
    id_rd_idx_r = rd;
    wb_stall_i  = (k > 0);
    e.data = exp_data;
    e.rd   = rd;
    sb_q.push_back(e);
    tick();
    id_valid_r = 1'b0;
    mul_res_r  = 64'hDEAD_BEEF_CAFE_F00D;
    check("stall_wait_first", {31'd0, ex_stall_o}, 32'd1);
    tick();
    ex_stall_mul_w = 1'b1;
    repeat (n) tick();
    check("stall_wait_busy", {31'd0, ex_stall_o}, 32'd1);
    ex_stall_mul_w = 1'b0;
    mul_res_r      = prod;
    tick();
    if (k > 0) begin
      check("stall_hold_wb", {31'd0, ex_stall_o}, 32'd1);
      repeat (k) tick();
      wb_stall_i = 1'b0;
    end
    #1 check("stall_hold_free", {31'd0, ex_stall_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; id_valid_r = 1'b0; id_alu_op_r = 4'd0; id_rd_idx_r = 5'd0;
    mul_res_r = 64'd0; ex_stall_mul_w = 1'b0; ex_flush_i = 1'b0; wb_stall_i = 1'b0;
    #12;
    check("rst_valid", {31'd0, ex_mul_valid_r}, 32'd0);
    check("rst_wdata", ex_mul_wdata_r, 32'd0);
    check("rst_rd", {27'd0, ex_mul_rd_r}, 32'd0);
    check("rst_stall", {31'd0, ex_stall_o}, 32'd0);
    tick();
    rst_i = 1'b0;

    do_mul(64'h0000_0000_0000_0040, 1'b0, 5'd3, 3, 0, 32'h0000_0040);
    do_mul(64'h4000_0000_0000_0000, 1'b1, 5'd5, 4, 0, 32'h4000_0000);
    do_mul(64'h4000_0000_0000_0000, 1'b1, 5'd6, 2, 0, 32'h4000_0000);
    do_mul(64'h4000_0000_0000_0000, 1'b0, 5'd7, 2, 0, 32'h0000_0000);
    do_mul(64'h0000_0000_0000_003F, 1'b0, 5'd9, 2, 3, 32'h0000_003F);

    // Flush mid-WAIT: the product must never reach writeback.
    tick();
    id_valid_r = 1'b1; id_alu_op_r = ALU_MULL; id_rd_idx_r = 5'd10;
    tick();
    id_valid_r = 1'b0;
    tick();
    ex_stall_mul_w = 1'b1;
    tick();
    ex_flush_i = 1'b1;
    tick();
    ex_flush_i = 1'b0;
    check("stall_drain", {31'd0, ex_stall_o}, 32'd1);
    tick();
    tick();
    check("stall_drain_late", {31'd0, ex_stall_o}, 32'd1);
    mul_res_r      = 64'h0000_0000_0000_1234;
    ex_stall_mul_w = 1'b0;
    tick();
    check("stall_after_drain", {31'd0, ex_stall_o}, 32'd0);
    do_mul(64'h0000_0000_0000_0006, 1'b0, 5'd11, 2, 0, 32'h0000_0006);

    // Reset during WAIT clears the held outputs immediately.
    tick();
    id_valid_r = 1'b1; id_alu_op_r = ALU_MULH; id_rd_idx_r = 5'd12;
    tick();
    id_valid_r = 1'b0;
    tick();
    ex_stall_mul_w = 1'b1;
    tick();
    rst_i = 1'b1;
    #1;
    check("arst_valid", {31'd0, ex_mul_valid_r}, 32'd0);
    check("arst_wdata", ex_mul_wdata_r, 32'd0);
    check("arst_rd", {27'd0, ex_mul_rd_r}, 32'd0);
    check("arst_stall", {31'd0, ex_stall_o}, 32'd0);
    ex_stall_mul_w = 1'b0;
    tick();
    rst_i = 1'b0;
    do_mul(64'h0000_0000_0000_0015, 1'b0, 5'd13, 3, 0, 32'h0000_0015);

`ifdef MUL_STALL_CNT_EN
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("cnt_reset", mul_stall_cnt_o, 32'd0);
    // (2+2) WAIT cycles, then (3+2) WAIT cycles plus one stalled HOLD cycle.
    do_mul(64'h0000_0000_0000_0010, 1'b0, 5'd14, 2, 0, 32'h0000_0010);
    do_mul(64'h0000_0002_0000_0000, 1'b1, 5'd15, 3, 1, 32'h0000_0002);
    tick();
    check("cnt_total", mul_stall_cnt_o, 32'd10);
`endif

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("sb_drained", sb_q.size(), 32'd0);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
